// File: rtl/clo_clz_selftest_pkg.sv
// -----------------------------------------------------------------------------
// clo_clz_selftest_pkg
// Shared definitions for the CLO/CLZ leading-count self-test sequencer:
// sequencer state encoding, sweep geometry, LFSR feedback constant, the
// first-failure field layout and the LFSR step function.
// -----------------------------------------------------------------------------
package clo_clz_selftest_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // Run lengths 0..32 for each option, CLZ block first, then CLO.
   localparam int unsigned VEC_PER_OPT  = 33;
   localparam int unsigned VEC_TOTAL    = 2 * VEC_PER_OPT;
   localparam logic [6:0]  IDX_LAST     = 7'(VEC_TOTAL - 1);
   localparam logic [6:0]  IDX_CLO_BASE = 7'(VEC_PER_OPT);

   // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   localparam logic [6:0] ERR_MAX = 7'd127;

   // first_fail layout: {option, expected run length}.
   typedef struct packed {
      logic       option;
      logic [5:0] count;
   } fail_t;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/clo_clz_selftest_if.sv
// -----------------------------------------------------------------------------
// clo_clz_selftest_if
// Bundles the self-test control/status signals and the link to the
// leading-count unit under test.
//   start       : one-cycle sweep request
//   busy/done   : sweep in progress / sweep finished (level)
//   pass        : valid with done, 1 when no mismatches were seen
//   err_cnt     : saturating mismatch count
//   first_fail  : {option, n} of the first mismatching vector
//   dut_option  : 1 = CLO, 0 = CLZ
//   dut_value   : stimulus word
//   dut_count   : count returned by the unit
// master = the sequencer, slave = the host/count-unit side.
// -----------------------------------------------------------------------------
interface clo_clz_selftest_if;

   logic        start;
   logic        busy;
   logic        done;
   logic        pass;
   logic [6:0]  err_cnt;
   logic [6:0]  first_fail;
   logic        dut_option;
   logic [31:0] dut_value;
   logic [31:0] dut_count;

   modport master (
      input  start, dut_count,
      output busy, done, pass, err_cnt, first_fail, dut_option, dut_value
   );

   modport slave (
      output start, dut_count,
      input  busy, done, pass, err_cnt, first_fail, dut_option, dut_value
   );

endinterface

// File: rtl/clo_clz_selftest_encode.sv
// -----------------------------------------------------------------------------
// lead_run_encode
// Combinational stimulus builder: produces a 32-bit word whose leading run of
// ones (option=1) or zeros (option=0) is exactly n long, followed by one
// terminating bit of the opposite value and then the tail bits.
//   option : 1 = leading ones, 0 = leading zeros
//   n      : run length, 0..32 (anything >= 32 gives a full-width run)
//   tail   : filler for the bits below the terminator
//   value  : encoded word
// -----------------------------------------------------------------------------
module lead_run_encode (
   input  logic        option,
   input  logic [5:0]  n,
   input  logic [31:0] tail,
   output logic [31:0] value
);

   logic [31:0] w_below;      // ones from the terminator position downwards
   logic [31:0] w_lead_mask;  // ones over the leading run
   logic [31:0] w_term;       // terminator position (zero when n >= 32)
   logic [31:0] w_tail_mask;  // ones strictly below the terminator

   // Shifting by 32 or more empties the vector, so n = 32 falls out as a
   // full run with no terminator and no tail.
   assign w_below     = 32'hFFFF_FFFF >> n;
   assign w_lead_mask = ~w_below;
   assign w_term      = 32'h8000_0000 >> n;
   assign w_tail_mask = w_below >> 1;

   assign value = option ? (w_lead_mask | (tail & w_tail_mask))
                         : (w_term      | (tail & w_tail_mask));

endmodule

// File: rtl/clo_clz_selftest.sv
// -----------------------------------------------------------------------------
// clo_clz_selftest
// Self-test sequencer for the CLO/CLZ leading-count unit. On start it issues
// 66 vectors (CLZ run lengths 0..32, then CLO 0..32) with LFSR tails, and
// compares the returned count DUT_LAT cycles after each vector appears.
//   clk    : core clock
//   resetn : asynchronous active-low reset
//   bus    : master side of clo_clz_selftest_if (control/status and count-unit
//            link)
// Parameters:
//   DUT_LAT : cycles between dut_value and a valid dut_count (0..3)
//   SEED    : LFSR reset value; zero is replaced by 1
// -----------------------------------------------------------------------------
module clo_clz_selftest
   import clo_clz_selftest_pkg::*;
#(
   parameter int          DUT_LAT = 0,
   parameter logic [31:0] SEED    = 32'hACE1_2B5D
) (
   input  logic                  clk,
   input  logic                  resetn,
   clo_clz_selftest_if.master    bus
);

   localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [1:0]  DRAIN_LAST = 2'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_accept;
   logic        w_issue;
   logic        w_finish;

   logic [6:0]  r_idx;
   logic [1:0]  r_drain;
   logic [31:0] r_lfsr;

   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [6:0]  r_err_cnt;
   fail_t       r_first_fail;
   logic        r_dut_option;
   logic [31:0] r_dut_value;

   logic        w_opt;
   logic [5:0]  w_n;
   logic [31:0] w_enc_value;

   // Expected-result pipeline; stage 0 is loaded together with dut_value.
   logic        r_pv   [0:DUT_LAT];
   fail_t       r_pexp [0:DUT_LAT];

   logic        w_cmp_valid;
   fail_t       w_cmp_exp;
   logic        w_mismatch;
   logic [6:0]  w_err_nxt;

   // --------------------------------------------------------------------------
   // Vector index -> (option, run length)
   // --------------------------------------------------------------------------
   assign w_opt = (r_idx >= IDX_CLO_BASE);
   assign w_n   = w_opt ? 6'(r_idx - IDX_CLO_BASE) : r_idx[5:0];

   lead_run_encode u_encode (
      .option (w_opt),
      .n      (w_n),
      .tail   (r_lfsr),
      .value  (w_enc_value)
   );

   // --------------------------------------------------------------------------
   // Sequencer FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_issue = 1'b1;
            if (r_idx == IDX_LAST) w_state_nxt = (DUT_LAT > 0) ? ST_DRAIN : ST_FIN;
         end
         ST_DRAIN: begin
            if (r_drain == DRAIN_LAST) w_state_nxt = ST_FIN;
         end
         ST_FIN: begin
            // First FIN cycle still has busy set: wrap up and ignore start.
            if (r_busy) begin
               w_finish = 1'b1;
            end else if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Issue path: index, drain counter, LFSR, registered stimulus
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_idx        <= '0;
         r_drain      <= '0;
         r_lfsr       <= SEED_EFF;
         r_dut_option <= 1'b0;
         r_dut_value  <= '0;
      end else begin
         r_drain <= (r_state == ST_DRAIN) ? r_drain + 2'd1 : 2'd0;
         if (w_accept) begin
            r_idx <= '0;
         end else if (w_issue) begin
            r_idx        <= r_idx + 7'd1;
            r_lfsr       <= lfsr_next(r_lfsr);
            r_dut_option <= w_opt;
            r_dut_value  <= w_enc_value;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Expected-count pipeline
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: this pipeline is small and its valid bits gate the compare,
         // so every stage is reset rather than left as uninitialised storage.
         for (int i = 0; i <= DUT_LAT; i++) begin
            r_pv[i]   <= 1'b0;
            r_pexp[i] <= '0;
         end
      end else begin
         r_pv[0]   <= w_issue;
         r_pexp[0] <= '{option: w_opt, count: w_n};
         for (int i = 1; i <= DUT_LAT; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_pexp[i] <= r_pexp[i-1];
         end
      end
   end

   assign w_cmp_valid = r_pv[DUT_LAT];
   assign w_cmp_exp   = r_pexp[DUT_LAT];
   assign w_mismatch  = w_cmp_valid && (bus.dut_count != {26'b0, w_cmp_exp.count});

   always_comb begin
      w_err_nxt = r_err_cnt;
      if (w_accept)                             w_err_nxt = '0;
      else if (w_mismatch && r_err_cnt != ERR_MAX) w_err_nxt = r_err_cnt + 7'd1;
   end

   // --------------------------------------------------------------------------
   // Status registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_cnt    <= '0;
         r_first_fail <= '0;
      end else begin
         r_err_cnt <= w_err_nxt;
         if (w_accept) begin
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_first_fail <= '0;
         end else begin
            if (w_mismatch && r_err_cnt == '0) r_first_fail <= w_cmp_exp;
            // The last compare can land on the same edge, hence w_err_nxt.
            if (w_finish) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (w_err_nxt == '0);
            end
         end
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.pass       = r_pass;
   assign bus.err_cnt    = r_err_cnt;
   assign bus.first_fail = r_first_fail;
   assign bus.dut_option = r_dut_option;
   assign bus.dut_value  = r_dut_value;

endmodule

// File: doc/clo_clz_selftest.md
# clo_clz_selftest

Built-in self-test sequencer for the core's CLO/CLZ leading-count unit. It drives the counter's value/option inputs and checks the returned count against the run length it encoded. It generates a 32-bit word with an exact leading run of ones (CLO) or zeros (CLZ) and randomised tail bits, then compares the counter's answer after a fixed latency. It sits beside the ALU's count unit and is triggered by a debug/CP0 start strobe.

## Interface
- DUT_LAT, 0, cycles from driving dut_value/dut_option to a valid dut_count (0..3; 0 = combinational).
- SEED, 32'hACE1_2B5D, LFSR reset seed; all-zero is illegal and is replaced by 32'h1.
- clk  in  1  core clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle strobe; begins a full sweep when idle.
- dut_option  out  1  1 = CLO, 0 = CLZ, to counter.
- dut_value  out  32  stimulus word, to counter.
- dut_count  in  32  counter result.
- busy  out  1  sweep in progress (issue or drain).
- done  out  1  level; sweep finished; held until next accepted start or reset.
- pass  out  1  valid when done; 1 iff zero mismatches.
- err_cnt  out  7  mismatch count, saturates at 127.
- first_fail  out  7  {option, count[5:0]} of first mismatching vector; 0 if none.

## Operation
- Reset: FSM IDLE; dut_option=0, dut_value=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, LFSR=SEED, idx=0.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE/FIN + start -> ISSUE; clears done, pass, err_cnt, first_fail; idx=0; LFSR not reseeded.
  - ISSUE: one vector per cycle, 66 total: idx 0..32 -> option 0, n=idx; idx 33..65 -> option 1, n=idx-33. After idx 65 -> DRAIN if DUT_LAT>0, else FIN.
  - DRAIN: DUT_LAT cycles, no new vectors; then FIN.
  - FIN: done=1, pass=(err_cnt==0); busy=0.
- start while busy ignored.
- Encoding (CLZ, n<32): bits [31:32-n]=0, bit[31-n]=1, bits below = LFSR. n=32: all zeros. CLO: bitwise dual (leading ones, terminating 0, tail = LFSR). n=0: bit31 is terminator.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advances once per issued vector only.
- Check: expected = {26'b0, n[5:0]}, carried with option in a DUT_LAT-deep valid pipeline; compared when the pipeline output is valid. Mismatch: err_cnt+1 (saturating); first_fail loaded only when err_cnt was 0.
- After FIN, dut_value/dut_option hold last vector.

## Timing
- dut_value/dut_option registered; vector k appears the cycle after its ISSUE edge.
- Compare of vector k at cycle (issue_k + 1 + DUT_LAT), sampling dut_count.
- Sweep: start accepted at edge 0; busy high from cycle 1; done high at cycle 66+DUT_LAT+2, busy low same cycle.
- Reset mid-sweep: all outputs to reset values immediately; no partial done.
- start same cycle as FIN entry: ignored (still busy).

## Structure
- Shared package: state encoding, VEC_TOTAL=66, LFSR polynomial constant, first_fail field layout.
- Sub-module lead_run_encode (combinational): inputs option, n[5:0], tail[31:0]; output value[31:0]; reusable by the ALU bench.
- Latency pipeline and LFSR inline.

## Test plan
- Ideal combinational counter model, DUT_LAT=0 -> done at cycle 68, pass=1, err_cnt=0, first_fail=0.
- Model returns count+1 only for option 1, n=5 -> pass=0, err_cnt=1, first_fail=7'b1_000101.
- Model stuck at 0 -> err_cnt=64 (all except n=0 both options), first_fail=7'b0_000001.
- DUT_LAT=2 with 2-stage registered model -> pass=1, done at cycle 70; no compare before first vector's result.
- resetn low at vector 20, then start -> sweep restarts from idx 0, LFSR=SEED, outputs reset during low.
- Encoder spot checks: CLZ n=32 -> 32'h0; CLO n=32 -> 32'hFFFF_FFFF; CLZ n=0 -> bit31=1; CLO n=31 -> 32'hFFFF_FFFE; start while busy ignored.
